i2s_tx: RTL

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/opl2_pkg.sv | 24 ++
 rtl/i2s_tx_if.sv | 33 +++
 rtl/i2s_tx_sample_fifo.sv | 55 +++++
 rtl/i2s_tx.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/opl2_pkg.sv
`default_nettype none
// ============================================================================
// Package     : opl2_pkg
// Description : Shared constants for the audio output path: DAC sample width,
//               I2S slot/frame geometry, default bit-clock divider and the
//               helper that places a sample in an I2S slot.
// Revision    : 1.0 - initial release
// ============================================================================
package opl2_pkg;

    localparam int DAC_OUTPUT_WIDTH     = 16;
    localparam int I2S_SLOT_WIDTH       = 32;
    localparam int I2S_BCLK_DIV_DEFAULT = 4;
    localparam int I2S_FRAME_BITS       = 2 * I2S_SLOT_WIDTH;

    // Left-justify a sample in a slot; the unused low bits are zero.
    function automatic logic [I2S_SLOT_WIDTH-1:0] i2s_slot_word(
        input logic [DAC_OUTPUT_WIDTH-1:0] smp
    );
        return {smp, {(I2S_SLOT_WIDTH - DAC_OUTPUT_WIDTH){1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_tx_if.sv
`default_nettype none
// ============================================================================
// Interface   : i2s_tx_if
// Description : Sample input strobe/data, flag clear, and the I2S serial
//               outputs plus sticky status flags of i2s_tx.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2s_tx_if;
    import opl2_pkg::*;

    logic                        sample_valid;
    logic [DAC_OUTPUT_WIDTH-1:0] sample;
    logic                        clear_flags;
    logic                        i2s_bclk;
    logic                        i2s_lrclk;
    logic                        i2s_data;
    logic                        overflow;
    logic                        underflow;

    // Sample producer / controller side
    modport master (
        output sample_valid, sample, clear_flags,
        input  i2s_bclk, i2s_lrclk, i2s_data, overflow, underflow
    );

    // Transmitter side
    modport slave (
        input  sample_valid, sample, clear_flags,
        output i2s_bclk, i2s_lrclk, i2s_data, overflow, underflow
    );

endinterface
`default_nettype wire

// File: rtl/i2s_tx_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo
// Description : Small synchronous FIFO for audio samples. Read data is the
//               head entry (show-ahead); push and pop may occur together,
//               including while full. Callers must not push when full unless
//               also popping, and must not pop when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] data,
    output logic             empty,
    output logic             full
);

    localparam int c_addr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_addr_w:0] r_wr_ptr;
    logic [c_addr_w:0] r_rd_ptr;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign data  = r_mem[r_rd_ptr[c_addr_w-1:0]];
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                   (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);

    // Storage write; when full with a pop, this overwrites the slot being read out now.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr[c_addr_w-1:0]] <= push_data;
        end
    end

    // Pointer advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx
// Description : Mono Philips-I2S transmitter. Each sample is sent MSB-first,
//               left-justified in both 32-bit slots of a 64-bit frame. A new
//               sample is taken one bit clock before each left-slot MSB; when
//               none is waiting the previous sample repeats.
//               Build option: define I2S_TX_FIFO_EN to buffer samples in a
//               FIFO_DEPTH-entry FIFO; otherwise a single holding register is
//               used and a write while it is full replaces the held sample.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx
    import opl2_pkg::*;
#(
    parameter int BCLK_DIV   = I2S_BCLK_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    i2s_tx_if.slave bus
);

    localparam int               c_div_w    = $clog2(BCLK_DIV);
    localparam int               c_cnt_w    = $clog2(I2S_FRAME_BITS);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(BCLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_right_start = c_cnt_w'(I2S_SLOT_WIDTH);

    if (BCLK_DIV < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("i2s_tx: BCLK_DIV must be >= 2 and FIFO_DEPTH a power of two >= 2");
    end

    logic [c_div_w-1:0]          r_div_cnt;
    logic                        r_bclk;
    logic                        r_lrclk;
    logic                        r_data;
    logic [c_cnt_w-1:0]          r_bit_cnt;
    logic [I2S_SLOT_WIDTH-1:0]   r_shift;
    logic [DAC_OUTPUT_WIDTH-1:0] r_last;
    logic                        r_overflow;
    logic                        r_underflow;

    logic                        w_tick;
    logic                        w_fall;
    logic                        w_load;
    logic [c_cnt_w-1:0]          w_bit_next;
    logic                        w_empty;
    logic                        w_pop;
    logic                        w_ovf_set;
    logic                        w_unf_set;
    logic [DAC_OUTPUT_WIDTH-1:0] w_head;
    logic [DAC_OUTPUT_WIDTH-1:0] w_next_sample;

    // Bit timing: a falling BCLK edge advances the bit counter; counter value 0
    // is the last bit of the right slot, which is when the next word is taken.
    assign w_tick        = (r_div_cnt == c_div_last);
    assign w_fall        = w_tick && r_bclk;
    assign w_bit_next    = r_bit_cnt + 1'b1;
    assign w_load        = w_fall && (w_bit_next == '0);
    assign w_pop         = w_load && !w_empty;
    assign w_unf_set     = w_load && w_empty;
    assign w_next_sample = w_empty ? r_last : w_head;

`ifdef I2S_TX_FIFO_EN
    logic w_full;
    logic w_push;

    // A full FIFO still accepts a sample on the cycle it is popped.
    assign w_push    = bus.sample_valid && (!w_full || w_pop);
    assign w_ovf_set = bus.sample_valid && w_full && !w_pop;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DAC_OUTPUT_WIDTH)
    ) u_sample_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (bus.sample),
        .data      (w_head),
        .empty     (w_empty),
        .full      (w_full)
    );
`else
    logic [DAC_OUTPUT_WIDTH-1:0] r_hold;
    logic                        r_hold_full;

    assign w_head    = r_hold;
    assign w_empty   = !r_hold_full;
    assign w_ovf_set = bus.sample_valid && r_hold_full && !w_pop;

    // Single-entry holding register; a new write always replaces the content.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_pop) r_hold_full <= 1'b0;
            if (bus.sample_valid) begin
                r_hold      <= bus.sample;
                r_hold_full <= 1'b1;
            end
        end
    end
`endif

    // Bit-clock divider and serializer; data and word select move only on BCLK falls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
            r_lrclk   <= 1'b1;
            r_data    <= 1'b0;
            r_bit_cnt <= '1;
            r_shift   <= '0;
            r_last    <= '0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            if (w_tick) r_bclk <= ~r_bclk;
            if (w_fall) begin
                r_bit_cnt <= w_bit_next;
                r_lrclk   <= w_bit_next[c_cnt_w-1];
                r_data    <= r_shift[I2S_SLOT_WIDTH-1];
                if (w_load) begin
                    r_shift <= i2s_slot_word(w_next_sample);
                    r_last  <= w_next_sample;
                end else if (w_bit_next == c_right_start) begin
                    r_shift <= i2s_slot_word(r_last);
                end else begin
                    r_shift <= {r_shift[I2S_SLOT_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    // Sticky status flags; a set event in the same cycle beats a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set)            r_overflow  <= 1'b1;
            else if (bus.clear_flags) r_overflow  <= 1'b0;
            if (w_unf_set)            r_underflow <= 1'b1;
            else if (bus.clear_flags) r_underflow <= 1'b0;
        end
    end

    assign bus.i2s_bclk  = r_bclk;
    assign bus.i2s_lrclk = r_lrclk;
    assign bus.i2s_data  = r_data;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;

endmodule
`default_nettype wire
